cam_rgb444_capture: RTL
=======================

Name: cam_rgb444_capture

Overview:
- Upstream capture stage for one camera channel; one instance per camera.
- Converts the 8-bit two-byte-per-pixel RGB444 sensor stream (vsync/href/data, qualified by a pclk strobe) into the parallel pixel-write stream consumed by the two-camera merge / overlay / address-generation chain.
- Outputs: write strobe, 12-bit pixel, line/pixel coordinates, and measured frame geometry.
- Optional 2:1 decimation in both axes.

Parameters:
CAM_DATA_WIDTH, 12, output pixel width (RGB444; fixed at 12)
CAM_LINE, 9, line coordinate / depth width
CAM_PIXEL, 10, pixel coordinate / width width

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous reset, active low
i_enable  in  1  capture enable
i_decimate  in  1  1 = keep even pixels of even lines only (2:1 each axis)
i_pclk_en  in  1  one-clk strobe: i_vsync/i_href/i_data valid this cycle
i_vsync  in  1  frame sync, high = vertical blank
i_href  in  1  line valid
i_data  in  8  sensor byte
o_we  out  1  pixel write strobe
o_data  out  CAM_DATA_WIDTH  {R[3:0],G[3:0],B[3:0]}
o_line  out  CAM_LINE  output line index of o_data
o_pixel  out  CAM_PIXEL  output pixel index of o_data
o_imag_depth  out  CAM_LINE  output lines in last complete frame
o_imag_width  out  CAM_PIXEL  output pixels per line in last complete frame
o_imag_resized  out  1  i_decimate as latched at frame start
o_frame_done  out  1  one-clk pulse at end of each complete frame

Behaviour:
- Inputs are acted on only in cycles with i_pclk_en=1; otherwise state holds and o_we=0.
- Reset (rst_n=0 at clk edge):
  - All outputs 0.
  - State = WAIT_FRAME.
  - Byte phase = 0; counters = 0.
- States:
  - WAIT_FRAME: no writes. On qualified i_vsync 1->0 with i_enable=1: latch i_decimate into o_imag_resized, clear line counter, go ACTIVE. Partial frames after reset/enable are discarded.
  - ACTIVE:
    - i_href=1: byte phase 0 stores i_data[3:0] as R; phase 1 forms {R, i_data[7:4], i_data[3:0]}.
    - i_href=0: byte phase forced to 0; an odd trailing byte is dropped.
    - On qualified i_vsync 0->1: go VBLANK.
  - VBLANK:
    - Latch o_imag_depth = output lines written and o_imag_width = max output pixels/line of the frame just ended.
    - Pulse o_frame_done for exactly 1 clk.
    - Go ACTIVE on next vsync 1->0 if i_enable=1, else WAIT_FRAME.
- Counters:
  - Raw pixel count increments after each phase-1 byte and clears on href 1->0.
  - Raw line count increments on href 1->0 only if the line carried >=1 pixel.
- Output indices:
  - Without decimation: o_pixel = raw pixel, o_line = raw line.
  - With decimation: o_pixel = raw pixel>>1, o_line = raw line>>1.
- Write suppression:
  - With decimation, a write occurs only when both raw bits[0] = 0.
  - No write once raw pixel > 2^CAM_PIXEL-1 or raw line > 2^CAM_LINE-1. Counters saturate, never wrap.
- Latency: o_we/o_data/o_line/o_pixel are registered and appear 1 clk after the phase-1 byte's pclk_en cycle. o_we is high exactly 1 clk per pixel.
- o_imag_depth/o_imag_width change only in the VBLANK entry cycle and hold otherwise. A frame with zero lines does not update them but still pulses o_frame_done.
- i_enable=0 mid-frame: next clk goes to WAIT_FRAME, o_we=0, o_frame_done not pulsed, geometry unchanged.
- rst_n=0 mid-line: the pending half-pixel is discarded. Capture restarts at the next full frame.
- i_vsync and i_href both high: vsync has priority; the href data is ignored and no write occurs.
- i_decimate changes mid-frame: ignored until the next frame start.

Test Plan:
1. Reset, enable=1, decimate=0, pclk_en every clk. Send 4 lines x 8 pixels, byte pairs 0x0A,0xBC. Expect:
   - 32 writes, o_data=12'hABC, o_pixel 0..7, o_line 0..3.
   - o_we 1 clk after each second byte.
   - At vsync rise: depth=4, width=8, one o_frame_done pulse.
2. Same frame with decimate=1. Expect 8 writes, o_pixel 0..3, o_line 0..1, depth=2, width=4, o_imag_resized=1.
3. Assert enable mid-frame (vsync low, href active). Expect no writes until the next vsync 1->0, then a full 4x8 frame captured.
4. pclk_en every 3rd clk, one line with 5 bytes. Expect:
   - 2 writes; 5th byte dropped.
   - Next line's first pixel has o_pixel=0.
   - No o_we in non-strobe cycles.
5. 1100-pixel line with CAM_PIXEL=10. Expect writes for pixels 0..1023 only, no wrap to 0, width=1023 saturated value per counter rule.
6. rst_n=0 for 1 clk after the first byte of a pixel. Expect all outputs 0 next clk, no write for that pixel, capture resumes only after the next vsync fall.

Source files
------------

// File: rtl/cam_rgb444_capture.sv
// Camera byte-stream capture: two RGB444 bytes per pixel into a
// registered pixel-write stream, with optional 2:1 decimation.
module cam_rgb444_capture #(
  parameter int CAM_DATA_WIDTH = 12,
  parameter int CAM_LINE       = 9,
  parameter int CAM_PIXEL      = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_enable,
  input  logic                      i_decimate,
  input  logic                      i_pclk_en,
  input  logic                      i_vsync,
  input  logic                      i_href,
  input  logic [7:0]                i_data,
  output logic                      o_we,
  output logic [CAM_DATA_WIDTH-1:0] o_data,
  output logic [CAM_LINE-1:0]       o_line,
  output logic [CAM_PIXEL-1:0]      o_pixel,
  output logic [CAM_LINE-1:0]       o_imag_depth,
  output logic [CAM_PIXEL-1:0]      o_imag_width,
  output logic                      o_imag_resized,
  output logic                      o_frame_done
);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    VBLANK     = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                 vs_q;
  logic                 hr_q;
  logic                 phase;
  logic [3:0]           r_nib;
  logic [CAM_PIXEL:0]   raw_pix;
  logic [CAM_LINE:0]    raw_line;
  logic [CAM_PIXEL-1:0] cur_w;
  logic [CAM_PIXEL-1:0] max_w;
  logic [CAM_LINE-1:0]  lines;

  logic                 q;
  logic                 vs_fall;
  logic                 vs_rise;
  logic                 href_eff;
  logic                 in_act;
  logic                 line_close;
  logic                 pix_done;
  logic                 dec_ok;
  logic                 wr_ok;
  logic                 frame_start;
  logic                 frame_end;
  logic [CAM_PIXEL-1:0] w_fin;
  logic [CAM_LINE-1:0]  d_fin;
  logic [CAM_PIXEL-1:0] pix_idx;
  logic [CAM_LINE-1:0]  line_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= WAIT_FRAME;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!i_enable) begin
      state_nxt = WAIT_FRAME;
    end else begin
      unique case (state)
        WAIT_FRAME: if (vs_fall) state_nxt = ACTIVE;
        ACTIVE:     if (vs_rise) state_nxt = VBLANK;
        VBLANK:     if (vs_fall) state_nxt = ACTIVE;
        default:    state_nxt = WAIT_FRAME;
      endcase
    end
  end

  // vsync masks href so blanking data never reaches the pixel path
  always_comb begin
    q           = i_pclk_en & i_enable;
    vs_fall     = q & vs_q & ~i_vsync;
    vs_rise     = q & ~vs_q & i_vsync;
    href_eff    = i_href & ~i_vsync;
    in_act      = (state == ACTIVE);
    line_close  = q & in_act & hr_q & ~href_eff;
    pix_done    = q & in_act & href_eff & phase;
    dec_ok      = ~o_imag_resized | (~raw_pix[0] & ~raw_line[0]);
    wr_ok       = pix_done & ~raw_pix[CAM_PIXEL]
                & ~raw_line[CAM_LINE] & dec_ok;
    frame_start = vs_fall & ~in_act;
    frame_end   = vs_rise & in_act;
    w_fin       = (cur_w > max_w) ? cur_w : max_w;
    d_fin       = lines;
    if (cur_w != '0 && lines != '1) d_fin = lines + 1'b1;
    pix_idx     = raw_pix[CAM_PIXEL-1:0];
    line_idx    = raw_line[CAM_LINE-1:0];
    if (o_imag_resized) begin
      pix_idx  = {1'b0, raw_pix[CAM_PIXEL-1:1]};
      line_idx = {1'b0, raw_line[CAM_LINE-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q           <= 1'b0;
      hr_q           <= 1'b0;
      phase          <= 1'b0;
      r_nib          <= '0;
      raw_pix        <= '0;
      raw_line       <= '0;
      cur_w          <= '0;
      max_w          <= '0;
      lines          <= '0;
      o_we           <= 1'b0;
      o_data         <= '0;
      o_line         <= '0;
      o_pixel        <= '0;
      o_imag_depth   <= '0;
      o_imag_width   <= '0;
      o_imag_resized <= 1'b0;
      o_frame_done   <= 1'b0;
    end else begin
      o_we         <= 1'b0;
      o_frame_done <= 1'b0;
      if (i_pclk_en) begin
        vs_q <= i_vsync;
        hr_q <= href_eff;
      end
      if (frame_start) begin
        o_imag_resized <= i_decimate;
        raw_line       <= '0;
        raw_pix        <= '0;
        phase          <= 1'b0;
        cur_w          <= '0;
        max_w          <= '0;
        lines          <= '0;
      end else if (q && in_act) begin
        if (href_eff) begin
          phase <= ~phase;
          if (!phase)                  r_nib   <= i_data[3:0];
          else if (!raw_pix[CAM_PIXEL]) raw_pix <= raw_pix + 1'b1;
        end else begin
          phase <= 1'b0;
        end
        // line bookkeeping is folded in at href fall or vsync rise
        if (line_close) begin
          raw_pix <= '0;
          cur_w   <= '0;
          max_w   <= w_fin;
          lines   <= d_fin;
          if (raw_pix != '0 && !raw_line[CAM_LINE])
            raw_line <= raw_line + 1'b1;
        end
        if (wr_ok) begin
          o_we    <= 1'b1;
          o_data  <= {r_nib, i_data};
          o_pixel <= pix_idx;
          o_line  <= line_idx;
          if (cur_w != '1) cur_w <= cur_w + 1'b1;
        end
        if (frame_end) begin
          o_frame_done <= 1'b1;
          if (d_fin != '0) begin
            o_imag_depth <= d_fin;
            o_imag_width <= w_fin;
          end
        end
      end
    end
  end

endmodule
